// File: rtl/prog_run_controller.sv
// prog_run_controller
//
// Loads a program into instruction memory from a byte stream, then lets the
// CPU free-run or single-step until it fetches a HALT instruction.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   load_start, load_len  begin a program load of load_len 16-bit words
//   byte_valid/byte_data  program byte stream (high byte of each word first)
//   byte_ready            a byte is accepted this cycle (LOAD_HI / LOAD_LO)
//   run_req, step_req     free-run / single-step requests
//   inst_op               opcode of the instruction the CPU is fetching
//   imem_we/addr/wdata    instruction-memory write port
//   cpu_en                CPU update enable for this cycle
//   cpu_rst_n             holds the CPU in reset while a load is in progress
//   halted                CPU has fetched HALT (opcode 4'hF)
//   load_err              last load request was rejected (too long)
//   state                 current FSM state encoding
//   cycle_cnt             saturating count of enabled CPU cycles
module prog_run_controller #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              run_req,
  input  logic              step_req,
  input  logic [3:0]        inst_op,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              halted,
  output logic              load_err,
  output logic [2:0]        state,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_RUN     = 3'd4,
    S_STEP    = 3'd5,
    S_HALTED  = 3'd6
  } state_e;

  localparam logic [3:0]      OpHalt = 4'hF;
  localparam logic [ADDR_W:0] MaxLen = MAX_WORDS[ADDR_W:0];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;

  logic                loadAccept;
  logic                inLoad;

  // The word counter is kept separately from the address so that a load of
  // exactly 2^ADDR_W words still terminates after the address wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign loadAccept = load_start &&
                      ((state_q == S_IDLE) || (state_q == S_RUN) ||
                       (state_q == S_STEP) || (state_q == S_HALTED));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    halted_d   = halted_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_req) begin
          state_d = S_RUN;
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end
      S_LOAD_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          wdata_d[15:8] = byte_data;
          state_d       = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          wdata_d[7:0] = byte_data;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        addr_d  = addr_q + 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_d < len_q) ? S_LOAD_HI : S_IDLE;
      end
      S_RUN: begin
        if (inst_op != OpHalt) begin
          cpu_en = 1'b1;
        end else begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end
      end
      S_STEP: begin
        if (inst_op != OpHalt) begin
          cpu_en  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cpu_en && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end

    // An accepted load pre-empts whatever RUN/STEP/IDLE decided above,
    // including a HALT fetched in the same cycle.
    if (loadAccept) begin
      halted_d = halted_q;
      if (load_len == '0) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end else if (load_len > MaxLen) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        err_d    = 1'b0;
        halted_d = 1'b0;
        cnt_d    = '0;
        addr_d   = '0;
        wcnt_d   = '0;
        len_d    = load_len;
        state_d  = S_LOAD_HI;
      end
    end
  end

  assign inLoad     = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO) ||
                      (state_q == S_WRITE);
  // Gated with rst_n so the CPU is held in reset for the whole reset pulse.
  assign cpu_rst_n  = rst_n & ~inLoad;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign halted     = halted_q;
  assign load_err   = err_q;
  assign state      = state_q;
  assign cycle_cnt  = cnt_q;

endmodule
